// File: rtl/machine_timer.sv
// machine_timer: 64-bit mtime/mtimecmp timer raising a level interrupt on int_flag_o[0].
// Define MTIMER_PRESCALER_EN to add the PRESCALE register and prescale counter.
module machine_timer #(
    parameter logic [31:0] ADDR_BASE = 32'h0200_0000,
    parameter int          INT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          data_i,
    output logic [31:0]          data_o,
    output logic                 rvalid_o,
    output logic [INT_WIDTH-1:0] int_flag_o
);
    logic        en, pend, periodic, ie;
    logic [63:0] mtime, mtimecmp, mtime_nxt;
    logic [31:0] shadow, rdata;
    logic [2:0]  off;
    logic        hit, wr, rd, ctrl_wr, stop, tick, match;
    logic        unused_addr;
    assign unused_addr = ^{addr_i[7:5], addr_i[1:0]};
    assign hit     = req_i && addr_i[31:8] == ADDR_BASE[31:8];
    assign wr      = hit && we_i;
    assign rd      = hit && !we_i;
    assign off     = addr_i[4:2];
    assign ctrl_wr = wr && off == 3'd0;
    // Clearing EN through CTRL kills any tick falling in the same cycle.
    assign stop    = ctrl_wr && !data_i[0];
`ifdef MTIMER_PRESCALER_EN
    logic [31:0] prescale, pcnt;
    assign tick = en && pcnt == prescale && !stop;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            pcnt     <= '0;
        end else begin
            if (wr && off == 3'd5) prescale <= data_i;
            pcnt <= (!en || stop || pcnt == prescale) ? '0 : pcnt + 32'd1;
        end
    end
`else
    assign tick = en && !stop;
`endif
    assign match = tick && mtime == mtimecmp;
    // Bus writes override whatever the tick would have done to mtime.
    always_comb begin
        mtime_nxt = tick ? ((match && periodic) ? '0 : mtime + 64'd1) : mtime;
        if (wr && off == 3'd1) mtime_nxt[31:0] = data_i;
        if (wr && off == 3'd2) mtime_nxt[63:32] = data_i;
    end
    always_comb begin
        rdata = '0;
        case (off)
            3'd0: rdata = {28'd0, ie, periodic, pend, en};
            3'd1: rdata = mtime[31:0];
            3'd2: rdata = shadow;
            3'd3: rdata = mtimecmp[31:0];
            3'd4: rdata = mtimecmp[63:32];
`ifdef MTIMER_PRESCALER_EN
            3'd5: rdata = prescale;
`endif
            default: rdata = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= 1'b0;
            pend     <= 1'b0;
            periodic <= 1'b0;
            ie       <= 1'b0;
            mtime    <= '0;
            mtimecmp <= '1;
            shadow   <= '0;
            data_o   <= '0;
            rvalid_o <= 1'b0;
        end else begin
            mtime    <= mtime_nxt;
            rvalid_o <= rd;
            data_o   <= rd ? rdata : '0;
            if (rd && off == 3'd1) shadow <= mtime[63:32];
            if (ctrl_wr) begin
                en       <= data_i[0];
                periodic <= data_i[2];
                ie       <= data_i[3];
            end
            pend <= match || (pend && !(ctrl_wr && data_i[1]));
            if (wr && off == 3'd3) mtimecmp[31:0] <= data_i;
            if (wr && off == 3'd4) mtimecmp[63:32] <= data_i;
        end
    end
    assign int_flag_o = INT_WIDTH'(pend & ie);
endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: directed bus sequences checked against a transaction-level timer model.
module tb_machine_timer;
    localparam int          IW   = 8;
    localparam logic [31:0] BASE = 32'h0200_0000;
    logic          clk, rst_n, req, we;
    logic [31:0]   addr, wdata, data_o;
    logic          rvalid;
    logic [IW-1:0] int_flag;
    int tests = 0, fails = 0;

    machine_timer #(.ADDR_BASE(BASE), .INT_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .data_i(wdata), .data_o(data_o), .rvalid_o(rvalid), .int_flag_o(int_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en, pend, per, ie, rv;
        logic [63:0] mt, cmp;
        logic [31:0] sh, ps, pc, rd;
    } st_t;
    st_t m;

    function automatic st_t reset_state();
        st_t s;
        s.en = 0; s.pend = 0; s.per = 0; s.ie = 0; s.rv = 0;
        s.mt = 64'd0; s.cmp = '1; s.sh = 0; s.ps = 0; s.pc = 0; s.rd = 0;
        return s;
    endfunction

    // One clock of timer behaviour, derived from the register-level rules.
    function automatic st_t step(st_t s, logic r, logic w, logic [31:0] a, logic [31:0] d);
        st_t n = s;
        logic hit = r && a[31:8] == BASE[31:8];
        int   reg_idx = int'(a[4:2]);
        logic is_wr = hit && w;
        logic is_rd = hit && !w;
        logic halt = is_wr && reg_idx == 0 && !d[0];
        logic ticking, matched;
`ifdef MTIMER_PRESCALER_EN
        ticking = s.en && s.pc == s.ps && !halt;
        n.pc = (s.en && !halt && s.pc != s.ps) ? s.pc + 1 : 0;
`else
        ticking = s.en && !halt;
`endif
        matched = ticking && s.mt == s.cmp;
        if (ticking) n.mt = (matched && s.per) ? 64'd0 : s.mt + 64'd1;
        n.rv = is_rd;
        n.rd = 0;
        if (is_rd) begin
            if (reg_idx == 0) n.rd = {28'd0, s.ie, s.per, s.pend, s.en};
            if (reg_idx == 1) begin n.rd = s.mt[31:0]; n.sh = s.mt[63:32]; end
            if (reg_idx == 2) n.rd = s.sh;
            if (reg_idx == 3) n.rd = s.cmp[31:0];
            if (reg_idx == 4) n.rd = s.cmp[63:32];
`ifdef MTIMER_PRESCALER_EN
            if (reg_idx == 5) n.rd = s.ps;
`endif
        end
        if (is_wr) begin
            if (reg_idx == 0) begin
                n.en = d[0]; n.per = d[2]; n.ie = d[3];
                if (d[1]) n.pend = 0;
            end
            if (reg_idx == 1) n.mt = {s.mt[63:32], d};
            if (reg_idx == 2) n.mt = {d, s.mt[31:0]};
            if (reg_idx == 3) n.cmp[31:0] = d;
            if (reg_idx == 4) n.cmp[63:32] = d;
`ifdef MTIMER_PRESCALER_EN
            if (reg_idx == 5) n.ps = d;
`endif
        end
        if (matched) n.pend = 1;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= reset_state();
        else m <= step(m, req, we, addr, wdata);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_rvalid", {63'd0, rvalid}, {63'd0, rst_n && m.rv});
        chk("cyc_data", {32'd0, data_o}, {32'd0, rst_n ? m.rd : 32'd0});
        chk("cyc_int", {{(64-IW){1'b0}}, int_flag}, {{(64-IW){1'b0}}, IW'(rst_n && m.pend && m.ie)});
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        req = 1; we = 1; addr = BASE | a; wdata = d;
        @(posedge clk); #1;
        req = 0; we = 0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        req = 1; we = 0; addr = BASE | a;
        @(posedge clk); #1;
        req = 0;
        chk(nm, {32'd0, data_o}, {32'd0, exp});
        chk({nm, "_rv"}, {63'd0, rvalid}, 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_int(input string nm, input logic v);
        chk(nm, {{(64-IW){1'b0}}, int_flag}, {{(64-IW){1'b0}}, IW'(v)});
    endtask

    initial begin
        rst_n = 0; req = 0; we = 0; addr = 0; wdata = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        // reset values
        rd(32'h00, 32'h0, "rst_ctrl");
        rd(32'h04, 32'h0, "rst_mtime_lo");
        rd(32'h08, 32'h0, "rst_mtime_hi");
        rd(32'h0C, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(32'h10, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(32'h14, 32'h0, "rst_prescale");
        rd(32'h18, 32'h0, "rst_unmapped");
        chk_int("rst_int", 0);
        // one-shot match
        wr(32'h0C, 5); wr(32'h10, 0); wr(32'h00, 32'h9);
        idle(5); chk_int("oneshot_pre", 0);
        idle(1); chk_int("oneshot_fire", 1);
        rd(32'h04, 32'd6, "oneshot_mtime");
        wr(32'h00, 32'hB); chk_int("oneshot_w1c", 0);
        rd(32'h00, 32'h9, "oneshot_ctrl");
        // periodic reload and set-beats-clear
        wr(32'h00, 0); wr(32'h04, 0); wr(32'h08, 0); wr(32'h0C, 3); wr(32'h10, 0);
        wr(32'h00, 32'hD);
        rd(32'h04, 0, "per_0"); rd(32'h04, 1, "per_1"); rd(32'h04, 2, "per_2");
        rd(32'h04, 3, "per_3"); rd(32'h04, 0, "per_4"); rd(32'h04, 1, "per_5");
        chk_int("per_pend", 1);
        wr(32'h00, 32'hF); chk_int("per_clr", 0);
        wr(32'h00, 32'hF); chk_int("per_set_wins", 1);
        // carry into upper word with atomic read
        wr(32'h00, 0); wr(32'h04, 32'hFFFF_FFFE); wr(32'h08, 0);
        wr(32'h0C, 32'hFFFF_FFFF); wr(32'h10, 32'hFFFF_FFFF); wr(32'h00, 32'h3);
        idle(1);
        rd(32'h04, 32'hFFFF_FFFF, "wrap_lo0");
        rd(32'h08, 32'h0, "wrap_hi0");
        rd(32'h04, 32'h1, "wrap_lo1");
        rd(32'h08, 32'h1, "wrap_hi1");
`ifdef MTIMER_PRESCALER_EN
        wr(32'h00, 0); wr(32'h04, 0); wr(32'h08, 0); wr(32'h14, 3); wr(32'h00, 1);
        idle(3);
        rd(32'h04, 0, "ps_before"); rd(32'h04, 1, "ps_after");
        wr(32'h00, 0); wr(32'h00, 1);
        idle(3);
        rd(32'h04, 1, "ps_restart_before"); rd(32'h04, 2, "ps_restart_after");
        rd(32'h14, 3, "ps_reg");
        wr(32'h14, 0);
`else
        wr(32'h14, 32'h7);
        rd(32'h14, 32'h0, "ps_absent");
`endif
        // write collides with tick
        wr(32'h00, 0); wr(32'h04, 32'hFF); wr(32'h08, 0); wr(32'h00, 1);
        wr(32'h04, 32'h100);
        rd(32'h04, 32'h100, "collide");
        // asynchronous reset with interrupt pending
        wr(32'h00, 0); wr(32'h04, 0); wr(32'h0C, 0); wr(32'h10, 0); wr(32'h00, 32'h9);
        idle(2); chk_int("prerst_int", 1);
        #2 rst_n = 0;
        #1 chk_int("async_rst_int", 0);
        chk("async_rst_rv", {63'd0, rvalid}, 64'd0);
        @(posedge clk); #1 rst_n = 1;
        rd(32'h04, 0, "postrst_mtime");
        rd(32'h0C, 32'hFFFF_FFFF, "postrst_cmp");
        rd(32'h00, 0, "postrst_ctrl");
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/machine_timer.md
# machine_timer

Memory-mapped machine timer that produces the timer interrupt request consumed by the core-local interrupt arbiter. It holds a 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register, and a sticky pending flag. It drives the core's `int_flag` input with a level request while the flag is pending and enabled. It sits on the peripheral bus next to the core and is cleared by software in the trap handler.

## Interface
- `ADDR_BASE`, default 32'h0200_0000: base address of the register window; a request selects the block when `addr_i[31:8] == ADDR_BASE[31:8]`.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_i` in 1: bus request, single-cycle strobe.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 32: byte address; `addr_i[4:2]` selects the register; `addr_i[1:0]` is ignored.
- `data_i` in 32: write data (full-word writes only).
- `data_o` out 32: read data, registered.
- `rvalid_o` out 1: `data_o` valid, one-cycle pulse.
- `int_flag_o` out `INT_WIDTH`: bit 0 = timer request; all other bits are 0. `INT_NONE` (all zero) when idle.

## Operation
Register map (offset):
- 0x00 CTRL: bit0 EN (count enable), bit1 PEND (read: flag; write 1 clears; write 0 has no effect), bit2 PERIODIC, bit3 IE. Other bits read 0.
- 0x04 MTIME_LO.
- 0x08 MTIME_HI.
- 0x0C MTIMECMP_LO.
- 0x10 MTIMECMP_HI.
- 0x14 PRESCALE: only present with the macro defined.
- All other offsets: reads return 0, writes are ignored.

Tick and counting:
- A tick is a cycle with EN=1 and the prescale counter equal to PRESCALE. The prescale counter then wraps to 0; otherwise it increments.
- The prescale counter is held at 0 while EN=0.
- On a tick with `mtime == mtimecmp`: PEND is set. If PERIODIC=1, `mtime` loads 0; otherwise it increments.
- On a tick with no match: `mtime` increments. The 64-bit add wraps from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag.

Interrupt output:
- `int_flag_o[0] = PEND & IE`. It is a combinational decode of registered bits.
- Writing MTIMECMP does not clear PEND. Only a CTRL write with bit1=1 clears it.

Atomic mtime read:
- A read of MTIME_LO returns the low word and latches `mtime[63:32]` into a shadow register in the same cycle.
- A read of MTIME_HI returns the shadow, not the live value.
- The shadow is reset to 0.

Simultaneous events:
- A bus write to MTIME_LO/HI in a tick cycle: the write wins and the tick's increment or reload is discarded. The compare in that cycle still uses the pre-write `mtime`.
- A PEND set event and a CTRL W1C in the same cycle: set wins, PEND=1.
- A CTRL write with EN=0 stops counting immediately and resets the prescale counter. The tick in that same cycle is suppressed.

## Timing
- Reset values: `data_o`=0, `rvalid_o`=0, `int_flag_o`=0, CTRL=0, `mtime`=0, `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, PRESCALE=0, prescale counter 0, shadow 0.
- Writes take effect at the clock edge ending the request cycle.
- Reads: `rvalid_o` and `data_o` appear the cycle after the request. `data_o` returns to 0 when `rvalid_o`=0.
- Match to interrupt: PEND and `int_flag_o[0]` go high at the edge that ends the matching tick cycle, i.e. the first cycle after the match.
- With PRESCALE=N, `mtime` advances once every N+1 cycles.
- Reset mid-count: all state returns to reset values asynchronously and the interrupt drops immediately.

## Configuration
- `MTIMER_PRESCALER_EN` defined: the PRESCALE register (32-bit, read/write) and the prescale counter exist.
- `MTIMER_PRESCALER_EN` undefined: every EN=1 cycle is a tick. Offset 0x14 reads 0 and writes to it are ignored. No prescale counter is instantiated.

## Test plan
- Reset, then read all offsets: CTRL=0, MTIME=0, MTIMECMP_LO/HI=0xFFFF_FFFF, `int_flag_o`=0, and `rvalid_o` pulses one cycle after each request.
- Write MTIMECMP={0,5}, then CTRL=0x9 (EN, IE), PRESCALE=0: `mtime` reaches 5 after 5 cycles, and `int_flag_o[0]`=1 one cycle later with `mtime`=6. Write CTRL=0xB: the flag drops the next cycle and EN stays 1.
- PERIODIC: MTIMECMP=3, CTRL=0xD: `mtime` sequence 0,1,2,3,0,1,…; PEND is set after the first 3. W1C on the same cycle as the second match keeps PEND=1.
- Wrap and atomic read: load `mtime`=0x0000_0000_FFFF_FFFE with EN=1. A read of MTIME_LO returning 0xFFFF_FFFF must be followed by an MTIME_HI read returning 0x0000_0000 even after the carry. The next LO/HI pair returns hi=1.
- Prescaler (macro on): PRESCALE=3, EN=1: `mtime` increments every 4 cycles. Clearing EN mid-period, then setting it again, restarts a full 4-cycle period. With the macro off, 0x14 reads 0 after a write of 0x7.
- Write collision: a write of MTIME_LO=0x100 on a tick cycle leaves `mtime`=0x100, not 0x101.
